// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver control: baud divisor staging, receive FIFO, overrun and interrupts.
// Optional idle-timeout interrupt is built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
   parameter int          DATA_WIDTH       = 8,
   parameter int          DEPTH_LOG2       = 4,
   parameter logic [15:0] DEFAULT_PRESCALE = 16'd54,
   parameter int          TIMEOUT_BITS     = 40
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_enable,
   input  logic                  cfg_baud_wr,
   input  logic [15:0]           cfg_baud_div,
   input  logic                  cfg_flush,
   input  logic [DEPTH_LOG2:0]   cfg_thresh,
   input  logic                  clr_overrun,
   output logic [15:0]           prescale,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_ready,
   input  logic                  rx_busy,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   input  logic                  pop_ready,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overrun,
   output logic                  irq_level,
   output logic                  irq_timeout
);

   localparam logic [1:0] ST_OFF  = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;

   localparam int                  LP_DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LP_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] LP_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] LP_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [15:0]           r_prescale;
   logic [15:0]           r_pend_div;
   logic                  r_pend_vld;
   logic                  w_pend_nxt;
   logic                  w_run;
   logic                  w_wr_en;
   logic                  w_wr_busy;
   logic                  w_wr_idle;

   logic [DATA_WIDTH-1:0] r_mem [LP_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_overrun;
   logic                  r_irq_level;
   logic                  w_full;
   logic                  w_push;
   logic                  w_push_ok;
   logic                  w_pop;
   logic                  w_ovf_set;

   assign w_run     = (r_state != ST_OFF);
   assign w_wr_en   = w_run && cfg_enable && cfg_baud_wr;
   assign w_wr_busy = w_wr_en && rx_busy;
   assign w_wr_idle = w_wr_en && !rx_busy;

   // A divisor stays pending while a frame is in flight, even after the block is disabled.
   assign w_pend_nxt = w_wr_busy || (r_pend_vld && rx_busy && !w_wr_idle);

   always_comb begin
      w_state_nxt = r_state;
      if (!cfg_enable) begin
         w_state_nxt = ST_OFF;
      end else if (w_pend_nxt) begin
         w_state_nxt = ST_PEND;
      end else begin
         w_state_nxt = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_OFF;
         r_prescale <= DEFAULT_PRESCALE;
         r_pend_div <= '0;
         r_pend_vld <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pend_vld <= w_pend_nxt;
         if (w_wr_busy) begin
            r_pend_div <= cfg_baud_div;
         end
         if (w_wr_idle) begin
            r_prescale <= cfg_baud_div;
         end else if (r_pend_vld && !rx_busy) begin
            r_prescale <= r_pend_div;
         end
      end
   end

   assign w_full    = (r_count == LP_FULL);
   assign pop_valid = (r_count != '0);
   assign w_push    = rx_ready && w_run;
   assign w_pop     = pop_valid && pop_ready;
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_ovf_set = w_push && w_full && !w_pop && !cfg_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LP_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (cfg_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= rx_data;
            r_wr_ptr        <= r_wr_ptr + LP_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + LP_CNT_ONE;
            2'b01:   r_count <= r_count - LP_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun   <= 1'b0;
         r_irq_level <= 1'b0;
      end else begin
         if (w_ovf_set) begin
            r_overrun <= 1'b1;
         end else if (clr_overrun) begin
            r_overrun <= 1'b0;
         end
         r_irq_level <= (cfg_thresh != '0) && (r_count >= cfg_thresh);
      end
   end

`ifdef UART_RX_CTRL_TIMEOUT_EN
   localparam int                   LP_IDLE_W    = $clog2(TIMEOUT_BITS + 1);
   localparam logic [LP_IDLE_W-1:0] LP_IDLE_MAX  = LP_IDLE_W'(TIMEOUT_BITS);
   localparam logic [LP_IDLE_W-1:0] LP_IDLE_LAST = LP_IDLE_W'(TIMEOUT_BITS - 1);

   logic [18:0]          r_bit_cnt;
   logic [LP_IDLE_W-1:0] r_idle_cnt;
   logic                 r_irq_timeout;
   logic [18:0]          w_period_m1;
   logic                 w_cnt_clr;
   logic                 w_bit_tick;
   logic                 w_idle_hit;

   // One bit period is prescale*8 clocks.
   assign w_period_m1 = {r_prescale, 3'b000} - 19'd1;
   assign w_cnt_clr   = w_push || w_pop || cfg_flush || (r_count == '0);
   assign w_bit_tick  = (r_bit_cnt == w_period_m1);
   assign w_idle_hit  = w_bit_tick && (r_idle_cnt == LP_IDLE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt     <= '0;
         r_idle_cnt    <= '0;
         r_irq_timeout <= 1'b0;
      end else begin
         if (w_cnt_clr) begin
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
         end else if (w_bit_tick) begin
            r_bit_cnt <= '0;
            if (r_idle_cnt != LP_IDLE_MAX) begin
               r_idle_cnt <= r_idle_cnt + {{(LP_IDLE_W-1){1'b0}}, 1'b1};
            end
         end else begin
            r_bit_cnt <= r_bit_cnt + 19'd1;
         end
         if (w_pop || cfg_flush) begin
            r_irq_timeout <= 1'b0;
         end else if (w_idle_hit) begin
            r_irq_timeout <= 1'b1;
         end
      end
   end

   assign irq_timeout = r_irq_timeout;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_BITS == 0);
   assign irq_timeout      = 1'b0;
`endif

   assign prescale  = r_prescale;
   assign pop_data  = r_mem[r_rd_ptr];
   assign level     = r_count;
   assign overrun   = r_overrun;
   assign irq_level = r_irq_level;

endmodule
